seg_scan_counter: RTL and testbench

- Parametrised successor to the team's 8-key seven-segment selector.
- Holds one BCD/hex digit register per channel. Debounces one active-low key per channel; each press increments that channel's digit.
- Time-multiplexes all digits onto a shared seg bus with a rotating sel index.
- Sits between the board key bank and the multiplexed seven-segment display.

---
 rtl/seg_scan_counter.sv | 140 ++++++++++++++
 tb/tb_seg_scan_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_counter.sv
// Per-channel debounced key counters, time-multiplexed onto a shared seven-segment bus.
// Each key bumps its own BCD/hex digit once per clean press; sel rotates through the digits.

module seg_scan_chan #(
  parameter int HEX_MODE        = 0,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_key,
  input  logic       i_clr,
  output logic [3:0] o_digit
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2, r_stable;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_digit;
  logic          w_done, w_press;

  // The press is recognised on the same edge that stable drops, so the digit
  // update lines up with the debounced level change.
  assign w_done  = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);
  assign w_press = w_done && r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= 4'd0;
    end else if (i_clr) begin
      r_digit <= 4'd0;
    end else if (w_press) begin
      r_digit <= (HEX_MODE != 0 || r_digit != 4'd9) ? r_digit + 4'd1 : 4'd0;
    end
  end

  assign o_digit = r_digit;
endmodule

module seg_scan_counter #(
  parameter int NUM_DIGITS      = 8,
  parameter int SEL_W           = 3,
  parameter int HEX_MODE        = 0,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   key,
  input  logic                    clr,
  output logic [SEL_W-1:0]        sel,
  output logic [7:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][3:0] w_digit;
  logic [PW-1:0]              r_presc;
  logic [SEL_W-1:0]           r_sel;
  logic [3:0]                 w_cur;
  logic [7:0]                 w_seg;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_chan
    seg_scan_chan #(
      .HEX_MODE       (HEX_MODE),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_key  (key[g]),
      .i_clr  (clr),
      .o_digit(w_digit[g])
    );
  end

  assign digits = w_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_sel   <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_sel   <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign sel   = r_sel;
  assign w_cur = w_digit[r_sel];

  // Active-high segments, bit7 (dp) held low.
  always_comb begin
    w_seg = 8'h00;
    case (w_cur)
      4'h0: w_seg = 8'h3f;
      4'h1: w_seg = 8'h06;
      4'h2: w_seg = 8'h5b;
      4'h3: w_seg = 8'h4f;
      4'h4: w_seg = 8'h66;
      4'h5: w_seg = 8'h6d;
      4'h6: w_seg = 8'h7d;
      4'h7: w_seg = 8'h07;
      4'h8: w_seg = 8'h7f;
      4'h9: w_seg = 8'h6f;
      4'ha: w_seg = 8'h77;
      4'hb: w_seg = 8'h7c;
      4'hc: w_seg = 8'h39;
      4'hd: w_seg = 8'h5e;
      4'he: w_seg = 8'h79;
      4'hf: w_seg = 8'h71;
      default: w_seg = 8'h00;
    endcase
  end

  assign seg = w_seg;
endmodule

// File: tb/tb_seg_scan_counter.sv
// Directed bench for seg_scan_counter: a decimal and a hex instance share one
// stimulus stream; expected digit vectors are queued at press time and popped on the update edge.

module tb_seg_scan_counter;
  localparam int ND = 8;
  localparam int SW = 3;
  localparam int DC = 4;
  localparam int SD = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clr = 1'b0;
  logic [ND-1:0]   key = '1;
  logic [SW-1:0]   sel_d, sel_h;
  logic [7:0]      seg_d, seg_h;
  logic [4*ND-1:0] dig_d, dig_h;

  always #5 clk = ~clk;

  seg_scan_counter #(.NUM_DIGITS(ND), .SEL_W(SW), .HEX_MODE(0),
                     .DEBOUNCE_CYCLES(DC), .SCAN_DIV(SD)) u_dec (
    .clk(clk), .rst(rst), .key(key), .clr(clr),
    .sel(sel_d), .seg(seg_d), .digits(dig_d));

  seg_scan_counter #(.NUM_DIGITS(ND), .SEL_W(SW), .HEX_MODE(1),
                     .DEBOUNCE_CYCLES(DC), .SCAN_DIV(SD)) u_hex (
    .clk(clk), .rst(rst), .key(key), .clr(clr),
    .sel(sel_h), .seg(seg_h), .digits(dig_h));

  typedef struct {
    string           tag;
    logic [4*ND-1:0] dec;
    logic [4*ND-1:0] hex;
  } exp_t;

  exp_t            sb[$];
  logic [4*ND-1:0] m_dec = '0;
  logic [4*ND-1:0] m_hex = '0;
  int              n_vec = 0;
  int              n_err = 0;
  int              scan_e;
  logic [7:0]      segtab [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                                   8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71};

  // edges seen since reset released; sel should step once per SD edges
  always @(posedge clk or posedge rst)
    if (rst) scan_e <= 0;
    else     scan_e <= scan_e + 1;

  function automatic int exp_sel();
    return (scan_e / SD) % ND;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_digits(input string tag);
    chk({tag, "_dec"}, 64'(dig_d), 64'(m_dec));
    chk({tag, "_hex"}, 64'(dig_h), 64'(m_hex));
  endtask

  task automatic push_press(input string tag, input logic [ND-1:0] mask);
    exp_t e;
    logic [3:0] d;
    e.tag = tag;
    e.dec = m_dec;
    e.hex = m_hex;
    for (int i = 0; i < ND; i++) begin
      if (mask[i]) begin
        d = m_dec[4*i +: 4];
        e.dec[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
        d = m_hex[4*i +: 4];
        e.hex[4*i +: 4] = d + 4'd1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic push_zero(input string tag);
    exp_t e;
    e.tag = tag;
    e.dec = '0;
    e.hex = '0;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_dec"}, 64'(dig_d), 64'(e.dec));
      chk({e.tag, "_hex"}, 64'(dig_h), 64'(e.hex));
      m_dec = e.dec;
      m_hex = e.hex;
    end
  endtask

  // key goes low before edge k0; digits must hold through k0+DC and move on k0+DC+1
  task automatic press(input string tag, input logic [ND-1:0] mask, input int hold);
    key = key & ~mask;
    push_press(tag, mask);
    step(DC + 1);
    check_digits({tag, "_pre"});
    step(1);
    pop_chk();
    if (hold > 0) begin
      step(hold);
      check_digits({tag, "_held"});
    end
    key = key | mask;
    step(DC + 4);
  endtask

  task automatic check_seg(input int ch);
    int n;
    n = 0;
    while (exp_sel() != ch && n < ND * SD + 2) begin
      step(1);
      n++;
    end
    chk("sel_dec", 64'(sel_d), 64'(ch));
    chk("sel_hex", 64'(sel_h), 64'(ch));
    chk("seg_dec", 64'(seg_d), 64'(segtab[m_dec[4*ch +: 4]]));
    chk("seg_hex", 64'(seg_h), 64'(segtab[m_hex[4*ch +: 4]]));
  endtask

  initial begin
    // reset state
    step(2);
    chk("rst_sel", 64'(sel_d), 64'd0);
    chk("rst_seg", 64'(seg_d), 64'h3f);
    check_digits("rst");
    rst = 1'b0;

    // scan rotation with all digits zero
    for (int i = 0; i < 26; i++) begin
      step(1);
      chk("scan_sel", 64'(sel_d), 64'(((i + 1) / SD) % ND));
      chk("scan_seg", 64'(seg_d), 64'h3f);
    end

    // clean press on key[2], held ~20 cycles in total
    press("press2", 8'h04, 14);
    check_seg(2);
    chk("seg2_is_06", 64'(seg_d), 64'h06);

    // bouncing key[0]: never stable long enough
    for (int i = 0; i < 6; i++) begin
      key[0] = (i % 2 == 1);
      step(2);
    end
    key[0] = 1'b1;
    step(DC + 4);
    check_digits("bounce");

    // 16 clean presses on key[0]: decimal wraps at 9, hex at F
    for (int i = 0; i < 16; i++) begin
      press("press0", 8'h01, 0);
      check_seg(0);
    end
    chk("dec_after16", 64'(m_dec[3:0]), 64'd6);

    // simultaneous presses on key[7] and key[3]
    press("press73", 8'h88, 2);

    // clr lands on the completion edge of a key[5] press
    key[5] = 1'b0;
    push_zero("clr5");
    step(DC + 1);
    check_digits("clr5_pre");
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    pop_chk();
    step(10);
    check_digits("clr5_held");
    key[5] = 1'b1;
    step(DC + 4);

    // reset in the middle of a key[1] debounce, key kept low through release
    key[1] = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel_dec", 64'(sel_d), 64'd0);
    chk("mid_rst_sel_hex", 64'(sel_h), 64'd0);
    chk("mid_rst_seg", 64'(seg_d), 64'h3f);
    check_digits("mid_rst");
    step(3);
    rst = 1'b0;
    push_press("rst_held1", 8'h02);
    step(DC);
    check_digits("rst_held1_pre");
    step(2);
    pop_chk();
    step(20);
    check_digits("rst_held1_norepeat");
    key[1] = 1'b1;
    step(DC + 4);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
